// File: rtl/breakout_pkg.sv
// Shared types, geometry, key codes and colours for the Breakout engine.
// brick_locate() is the one brick hit-test used by both physics and rendering.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_OVER = 3'd2,
    ST_WIN  = 3'd3
  } game_state_e;

  // 11 bits holds every on-screen coordinate plus an object size without wrapping.
  typedef logic [10:0] coord_t;

  localparam coord_t SCREEN_W     = 11'd640;
  localparam coord_t SCREEN_H     = 11'd480;
  localparam coord_t PADDLE_W     = 11'd64;
  localparam coord_t PADDLE_H     = 11'd8;
  localparam coord_t PADDLE_Y     = 11'd450;
  localparam coord_t PADDLE_X_MAX = 11'd576;
  localparam coord_t PADDLE_X_RST = 11'd288;
  localparam coord_t BALL_SIZE    = 11'd8;
  localparam coord_t BALL_HALF    = 11'd4;
  localparam coord_t BALL_X_MAX   = 11'd632;
  localparam coord_t BALL_Y_MAX   = 11'd472;
  localparam coord_t BALL_PARK_Y  = 11'd442;
  localparam coord_t BALL_PARK_DX = 11'd28;
  localparam coord_t BRICK_W      = 11'd80;
  localparam coord_t BRICK_H      = 11'd20;
  localparam coord_t BRICK_Y0     = 11'd40;
  localparam coord_t BRICK_INSET  = 11'd2;
  localparam int     BRICK_COLS   = 8;
  localparam int     BRICK_ROWS   = 4;

  localparam logic [4:0] KEY_LEFT   = 5'h0C;
  localparam logic [4:0] KEY_RIGHT  = 5'h0E;
  localparam logic [4:0] KEY_LAUNCH = 5'h10;
  localparam logic [4:0] KEY_PAUSE  = 5'h12;

  localparam logic [11:0] COL_BALL    = 12'hFFF;
  localparam logic [11:0] COL_PADDLE  = 12'h0FF;
  localparam logic [11:0] COL_BG_PLAY = 12'h000;
  localparam logic [11:0] COL_BG_OVER = 12'h400;
  localparam logic [11:0] COL_BG_WIN  = 12'h040;
  localparam logic [11:0] COL_BLANK   = 12'h000;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } brick_loc_t;

  function automatic logic [11:0] brick_colour(input logic [1:0] row);
    case (row)
      2'd0:    return 12'hF00;
      2'd1:    return 12'hF80;
      2'd2:    return 12'hFF0;
      default: return 12'h0F0;
    endcase
  endfunction

  // Brick slot containing (x, y), shrunk by inset on every side; ignores the mask.
  function automatic brick_loc_t brick_locate(input coord_t x, input coord_t y,
                                              input coord_t inset);
    brick_loc_t loc;
    coord_t     x0;
    coord_t     y0;
    loc = '0;
    for (int r = 0; r < BRICK_ROWS; r++) begin
      for (int c = 0; c < BRICK_COLS; c++) begin
        x0 = BRICK_W * coord_t'(c);
        y0 = BRICK_Y0 + BRICK_H * coord_t'(r);
        if (x >= x0 + inset && x < x0 + BRICK_W - inset &&
            y >= y0 + inset && y < y0 + BRICK_H - inset) begin
          loc.valid = 1'b1;
          loc.idx   = 5'(BRICK_COLS * r + c);
        end
      end
    end
    return loc;
  endfunction

endpackage

// File: rtl/breakout_render.sv
// Per-pixel hit-tests against the current game state, registered once
// so pixel follows row_addr/col_addr by one clock.
module breakout_render
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  game_state_e game_state,
  input  coord_t      px,
  input  coord_t      bx,
  input  coord_t      by,
  input  logic [31:0] mask,
  output logic [11:0] pixel
);

  coord_t      x;
  coord_t      y;
  brick_loc_t  loc;
  logic        ball_on;
  logic        paddle_on;
  logic [11:0] colour;

  assign x   = coord_t'(col_addr);
  assign y   = coord_t'(row_addr);
  assign loc = brick_locate(x, y, BRICK_INSET);

  assign ball_on   = x >= bx && x < bx + BALL_SIZE && y >= by && y < by + BALL_SIZE;
  assign paddle_on = x >= px && x < px + PADDLE_W && y >= PADDLE_Y && y < PADDLE_Y + PADDLE_H;

  always_comb begin
    case (game_state)
      ST_OVER: colour = COL_BG_OVER;
      ST_WIN:  colour = COL_BG_WIN;
      default: colour = COL_BG_PLAY;
    endcase
    if (x >= SCREEN_W || y >= SCREEN_H) colour = COL_BLANK;
    else if (ball_on)                   colour = COL_BALL;
    else if (paddle_on)                 colour = COL_PADDLE;
    else if (loc.valid && mask[loc.idx]) colour = brick_colour(loc.idx[4:3]);
  end

  always_ff @(posedge clk) begin
    if (rst) pixel <= '0;
    else     pixel <= colour;
  end

endmodule

// File: rtl/breakout_engine.sv
// Breakout game FSM and per-frame physics; pixel generation lives in breakout_render.
// Key edges are latched between frame ticks and consumed on the tick.
module breakout_engine
  import breakout_pkg::*;
#(
  parameter int PADDLE_STEP = 8,
  parameter int BALL_STEP   = 2,
  parameter int START_LIVES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic [4:0]  key_code,
  input  logic        key_ready,
  output logic [11:0] pixel,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  game_state
);

  localparam coord_t      P_STEP     = coord_t'(PADDLE_STEP);
  localparam coord_t      B_STEP     = coord_t'(BALL_STEP);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
  localparam logic [31:0] MASK_FULL  = '1;

  game_state_e state_q, state_d;
  coord_t      px_q, px_d, bx_q, bx_d, by_q, by_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [31:0] mask_q, mask_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        paused_q, paused_d;
  logic        key_q;
  logic        edge_valid_q, edge_valid_d;
  logic [4:0]  edge_code_q, edge_code_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      px_q         <= PADDLE_X_RST;
      bx_q         <= PADDLE_X_RST + BALL_PARK_DX;
      by_q         <= BALL_PARK_Y;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b0;
      mask_q       <= MASK_FULL;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      paused_q     <= 1'b0;
      key_q        <= 1'b0;
      edge_valid_q <= 1'b0;
      edge_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      mask_q       <= mask_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      paused_q     <= paused_d;
      key_q        <= key_ready;
      edge_valid_q <= edge_valid_d;
      edge_code_q  <= edge_code_d;
    end
  end

  // A rising edge in the tick cycle itself counts for that tick.
  logic       key_rise, edge_valid, launch_evt, pause_evt;
  logic [4:0] edge_code;
  assign key_rise   = key_ready & ~key_q;
  assign edge_valid = key_rise | edge_valid_q;
  assign edge_code  = key_rise ? key_code : edge_code_q;
  assign launch_evt = edge_valid && edge_code == KEY_LAUNCH;
  assign pause_evt  = edge_valid && edge_code == KEY_PAUSE;

  always_comb begin
    edge_valid_d = edge_valid_q;
    edge_code_d  = edge_code_q;
    if (frame_tick) begin
      edge_valid_d = 1'b0;
    end else if (key_rise) begin
      edge_valid_d = 1'b1;
      edge_code_d  = key_code;
    end
  end

  coord_t px_move;
  always_comb begin
    px_move = px_q;
    if (key_ready && key_code == KEY_LEFT)
      px_move = (px_q > P_STEP) ? px_q - P_STEP : '0;
    else if (key_ready && key_code == KEY_RIGHT)
      px_move = (px_q + P_STEP > PADDLE_X_MAX) ? PADDLE_X_MAX : px_q + P_STEP;
  end

  // Candidate position clamps at 0 so "<= 0" becomes "== 0" in unsigned terms.
  coord_t      nx, ny;
  brick_loc_t  brick;
  logic        brick_hit, paddle_hit, miss;
  logic [31:0] mask_cleared;
  assign nx = dir_x_q ? bx_q + B_STEP : ((bx_q > B_STEP) ? bx_q - B_STEP : '0);
  assign ny = dir_y_q ? by_q + B_STEP : ((by_q > B_STEP) ? by_q - B_STEP : '0);
  assign brick        = brick_locate(nx + BALL_HALF, ny + BALL_HALF, '0);
  assign brick_hit    = brick.valid && mask_q[brick.idx];
  assign mask_cleared = mask_q & ~(32'd1 << brick.idx);
  assign miss         = dir_y_q && ny >= BALL_Y_MAX;
  assign paddle_hit   = dir_y_q && ny >= BALL_PARK_Y && ny <= PADDLE_Y &&
                        nx + BALL_SIZE > px_move && nx < px_move + PADDLE_W;

  // NOTE: every signal is given a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    mask_d   = mask_q;
    score_d  = score_q;
    lives_d  = lives_q;
    paused_d = paused_q;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          px_d = px_move;
          bx_d = px_move + BALL_PARK_DX;
          by_d = BALL_PARK_Y;
          if (launch_evt) begin
            state_d = ST_PLAY;
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
          end
        end

        ST_PLAY: begin
          paused_d = paused_q ^ pause_evt;
          if (!paused_d) begin
            px_d = px_move;
            if (miss) begin
              state_d = (lives_q > 2'd1) ? ST_IDLE : ST_OVER;
              lives_d = (lives_q > 2'd1) ? lives_q - 2'd1 : 2'd0;
              bx_d    = px_move + BALL_PARK_DX;
              by_d    = BALL_PARK_Y;
              dir_x_d = 1'b1;
              dir_y_d = 1'b0;
            end else begin
              if (nx == '0) begin
                bx_d    = '0;
                dir_x_d = 1'b1;
              end else if (nx >= BALL_X_MAX) begin
                bx_d    = BALL_X_MAX;
                dir_x_d = 1'b0;
              end else begin
                bx_d = nx;
              end

              if (ny == '0) begin
                by_d    = '0;
                dir_y_d = 1'b1;
              end else if (paddle_hit) begin
                by_d    = BALL_PARK_Y;
                dir_y_d = 1'b0;
              end else if (brick_hit) begin
                mask_d  = mask_cleared;
                score_d = score_q + 8'd1;
                dir_y_d = ~dir_y_q;
                if (mask_cleared == '0) state_d = ST_WIN;
              end else begin
                by_d = ny;
              end
            end
          end
        end

        default: begin
          if (launch_evt) begin
            state_d = ST_IDLE;
            mask_d  = MASK_FULL;
            score_d = '0;
            lives_d = LIVES_INIT;
            px_d    = PADDLE_X_RST;
            bx_d    = PADDLE_X_RST + BALL_PARK_DX;
            by_d    = BALL_PARK_Y;
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
          end
        end
      endcase
    end

    if (state_d != ST_PLAY) paused_d = 1'b0;
  end

  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;

  breakout_render u_render (
    .clk        (clk),
    .rst        (rst),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .game_state (state_q),
    .px         (px_q),
    .bx         (bx_q),
    .by         (by_q),
    .mask       (mask_q),
    .pixel      (pixel)
  );

endmodule

// File: tb/tb_breakout_engine.sv
// Self-checking bench for breakout_engine: table-driven pixel probes through a
// latency-1 scoreboard, plus scripted game sequences.
module tb_breakout_engine;
  import breakout_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic [4:0]  key_code = '0;
  logic        key_ready = 1'b0;
  logic [11:0] pixel;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic [2:0]  game_state;

  always #5 clk = ~clk;

  breakout_engine #(.PADDLE_STEP(8), .BALL_STEP(2), .START_LIVES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .pixel      (pixel),
    .score      (score),
    .lives      (lives),
    .game_state (game_state)
  );

  typedef struct {
    int          phase;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] exp;
  } pix_vec_t;

  pix_vec_t    vecs[$];
  logic [11:0] exp_q[$];
  int          idx_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void add_vec(input int p, input int r, input int c, input logic [11:0] e);
    pix_vec_t v;
    v.phase = p;
    v.row   = 9'(r);
    v.col   = 10'(c);
    v.exp   = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_compare();
    logic [11:0] e;
    int          i;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i = idx_q.pop_front();
      check($sformatf("pixel[p%0d r%0d c%0d]", vecs[i].phase, vecs[i].row, vecs[i].col),
            32'(pixel), 32'(e));
    end
  endtask

  task automatic render_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        @(negedge clk);
        sb_compare();
        row_addr = vecs[i].row;
        col_addr = vecs[i].col;
        exp_q.push_back(vecs[i].exp);
        idx_q.push_back(i);
      end
    end
    @(negedge clk);
    sb_compare();
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [4:0] c);
    @(negedge clk);
    key_ready = 1'b0;
    @(negedge clk);
    key_code  = c;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic hold_left(input int n);
    @(negedge clk);
    key_code  = KEY_LEFT;
    key_ready = 1'b1;
    repeat (n) tick();
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit_at;
    int steps;

    // phase 0: reset state
    add_vec(0, 444, 320, 12'hFFF);
    add_vec(0, 452, 300, 12'h0FF);
    add_vec(0,  50,  10, 12'hF00);
    add_vec(0,  70, 100, 12'hF80);
    add_vec(0,  90, 170, 12'hFF0);
    add_vec(0, 110, 330, 12'h0F0);
    add_vec(0,  41,  10, 12'h000);
    add_vec(0,  50,  79, 12'h000);
    add_vec(0,   0,   0, 12'h000);
    add_vec(0, 480, 100, 12'h000);
    add_vec(0, 100, 640, 12'h000);
    // phase 1: paddle saturated at 0, ball parked at 28
    add_vec(1, 444,  28, 12'hFFF);
    add_vec(1, 449,  35, 12'hFFF);
    add_vec(1, 444,  27, 12'h000);
    add_vec(1, 452,   0, 12'h0FF);
    add_vec(1, 452,  63, 12'h0FF);
    add_vec(1, 452,  64, 12'h000);
    // phase 2: one tick after the first brick hit, ball heading down
    add_vec(2, 124, 360, 12'hFFF);
    add_vec(2, 115, 360, 12'h000);
    add_vec(2, 110, 330, 12'h000);
    add_vec(2, 110, 410, 12'h0F0);
    // phase 3: game over
    add_vec(3, 300, 600, 12'h400);
    add_vec(3,   0,   0, 12'h400);
    add_vec(3, 110, 330, 12'h400);
    add_vec(3,  50,  10, 12'hF00);
    // phase 4: after restart
    add_vec(4, 110, 330, 12'h0F0);
    add_vec(4, 452, 300, 12'h0FF);
    add_vec(4, 452,  10, 12'h000);
    add_vec(4, 444, 320, 12'hFFF);
    add_vec(4, 300, 600, 12'h000);
    // phase 5: win
    add_vec(5, 300, 600, 12'h040);
    add_vec(5, 110, 330, 12'h040);
    add_vec(5,  50,  10, 12'h040);
    // phase 6: paused with ball at (326,432)
    add_vec(6, 432, 326, 12'hFFF);
    add_vec(6, 439, 333, 12'hFFF);
    add_vec(6, 431, 326, 12'h000);
    add_vec(6, 440, 333, 12'h000);
    // phase 7: resumed, ball at (328,430)
    add_vec(7, 430, 328, 12'hFFF);
    add_vec(7, 437, 335, 12'hFFF);
    add_vec(7, 438, 328, 12'h000);
    // phase 8: after mid-game reset
    add_vec(8, 444, 320, 12'hFFF);
    add_vec(8, 452, 300, 12'h0FF);
    add_vec(8,  50,  10, 12'hF00);
    add_vec(8, 110, 330, 12'h0F0);

    // Reset values
    repeat (2) @(negedge clk);
    check("reset pixel", 32'(pixel), 32'h0);
    check("reset state", 32'(game_state), 32'(ST_IDLE));
    check("reset score", 32'(score), 32'd0);
    check("reset lives", 32'(lives), 32'd3);
    rst = 1'b0;
    render_phase(0);

    // Paddle saturation at the left edge, ball tracks it
    hold_left(40);
    check("idle state after move", 32'(game_state), 32'(ST_IDLE));
    render_phase(1);

    // Launch and run to the first brick
    press(KEY_LAUNCH);
    tick();
    check("launch state", 32'(game_state), 32'(ST_PLAY));
    hit_at = 0;
    for (int k = 1; k <= 400 && hit_at == 0; k++) begin
      tick();
      if (score != 8'd0) hit_at = k;
    end
    check("first brick tick", 32'(hit_at), 32'd164);
    check("score after brick", 32'(score), 32'd1);
    tick();
    render_phase(2);

    // Last life lost -> OVER
    @(negedge clk);
    force dut.lives_q = 2'd1;
    @(negedge clk);
    release dut.lives_q;
    steps = 0;
    while (game_state == 3'(ST_PLAY) && steps < 600) begin
      tick();
      steps++;
    end
    check("over state", 32'(game_state), 32'(ST_OVER));
    check("over lives", 32'(lives), 32'd0);
    check("over score", 32'(score), 32'd1);
    render_phase(3);

    // Restart from OVER
    press(KEY_LAUNCH);
    tick();
    check("restart state", 32'(game_state), 32'(ST_IDLE));
    check("restart lives", 32'(lives), 32'd3);
    check("restart score", 32'(score), 32'd0);
    render_phase(4);

    // Single remaining brick -> WIN
    hold_left(40);
    @(negedge clk);
    force dut.mask_q = 32'h1000_0000;
    @(negedge clk);
    release dut.mask_q;
    press(KEY_LAUNCH);
    tick();
    hit_at = 0;
    for (int k = 1; k <= 400 && hit_at == 0; k++) begin
      tick();
      if (game_state != 3'(ST_PLAY)) hit_at = k;
    end
    check("win tick", 32'(hit_at), 32'd164);
    check("win state", 32'(game_state), 32'(ST_WIN));
    check("win score", 32'(score), 32'd1);
    render_phase(5);

    // Pause freezes the ball, a second edge resumes
    press(KEY_LAUNCH);
    tick();
    check("restart from win", 32'(game_state), 32'(ST_IDLE));
    press(KEY_LAUNCH);
    tick();
    repeat (5) tick();
    press(KEY_PAUSE);
    tick();
    check("paused state", 32'(game_state), 32'(ST_PLAY));
    render_phase(6);
    repeat (10) tick();
    render_phase(6);
    press(KEY_PAUSE);
    tick();
    render_phase(7);

    // Reset in the middle of play
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midgame reset pixel", 32'(pixel), 32'h0);
    check("midgame reset state", 32'(game_state), 32'(ST_IDLE));
    check("midgame reset score", 32'(score), 32'd0);
    check("midgame reset lives", 32'(lives), 32'd3);
    rst = 1'b0;
    render_phase(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
